ps2_mouse_rx: RTL

- Receive-only PS/2 mouse front end: deserialises 11-bit PS/2 frames, groups bytes into movement packets, and publishes them as the 29-bit mouse packet bus.
- Drives ps2_mouse[28:0] straight into the Kempston mouse port logic, which detects a new packet when bit 28 changes level.
- Host-to-device commands (reset, sample rate, wheel enable) are out of scope; the mouse source is already initialised when it reaches this block.

---
 rtl/ps2_mouse_rx.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_rx.sv
// ---------------------------------------------------------------------------
// ps2_mouse_rx
//
// Receive-only PS/2 mouse front end. It filters the PS/2 clock, deserialises
// 11-bit frames (start, 8 data LSB first, odd parity, stop), groups the bytes
// into movement packets, and publishes each complete packet on ps2_mouse.
// Bit 28 toggles once per published packet so that the consumer can detect a
// new packet by a level change.
//
// Optional feature macro: PS2_MOUSE_WHEEL_EN
//   defined   : 4-byte IntelliMouse packets, [27:24] = byte3[3:0]
//   undefined : 3-byte packets, [27:24] = 0, no byte3 staging
//
// Ports
//   clk_sys    in   1   system clock, the only clock in the block
//   reset      in   1   asynchronous, active-high reset
//   ps2_clk    in   1   PS/2 clock line (asynchronous, idles high)
//   ps2_dat    in   1   PS/2 data line (asynchronous)
//   ps2_mouse  out 29   [7:0] status, [15:8] dx, [23:16] dy,
//                       [27:24] wheel, [28] packet toggle
//   err        out  1   one-cycle pulse on a frame error or bit timeout
// ---------------------------------------------------------------------------
module ps2_mouse_rx #(
  parameter int FILT_LEN    = 8,      // equal samples before filtered clock moves (>= 2)
  parameter int BIT_TIMEOUT = 5600,   // idle cycles inside a frame before abort
  parameter int PKT_TIMEOUT = 56000   // cycles without a byte before packet resync
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [28:0] ps2_mouse,
  output logic        err
);

`ifdef PS2_MOUSE_WHEEL_EN
  localparam int PKT_BYTES = 4;
`else
  localparam int PKT_BYTES = 3;
`endif

  localparam int FW = $clog2(FILT_LEN);
  localparam int BW = $clog2(BIT_TIMEOUT);
  localparam int PW = $clog2(PKT_TIMEOUT);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_TIMEOUT - 1);
  localparam logic [PW-1:0] PKT_LAST  = PW'(PKT_TIMEOUT - 1);
  localparam logic [1:0]    IDX_LAST  = 2'(PKT_BYTES - 1);

  // Input synchronisers and clock filter
  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_q,     filt_d;
  logic          fall_q,     fall_d;

  // Frame deserialiser
  logic [3:0]    bit_cnt_q,  bit_cnt_d;
  logic [BW-1:0] bit_tmr_q,  bit_tmr_d;
  logic [7:0]    shift_q,    shift_d;
  logic          par_q,      par_d;

  // Packet assembly and output
  logic [1:0]    pkt_idx_q,  pkt_idx_d;
  logic [PW-1:0] pkt_tmr_q,  pkt_tmr_d;
  logic [7:0]    b0_q,       b0_d;
  logic [7:0]    b1_q,       b1_d;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0]    b2_q,       b2_d;
`endif
  logic [28:0]   ps2_mouse_q, ps2_mouse_d;
  logic          err_q,       err_d;

  // Intermediate decode results
  logic          dat_bit;
  logic          bit_expire;
  logic [3:0]    bit_cnt_eff;
  logic          byte_done;
  logic          frame_err;
  logic          pkt_expire;
  logic [1:0]    pkt_idx_eff;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    dat_sync_d  = {dat_sync_q[0], ps2_dat};
    filt_cnt_d  = '0;
    filt_d      = filt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    pkt_idx_d   = pkt_idx_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
`ifdef PS2_MOUSE_WHEEL_EN
    b2_d        = b2_q;
`endif
    ps2_mouse_d = ps2_mouse_q;
    err_d       = 1'b0;
    byte_done   = 1'b0;
    frame_err   = 1'b0;
    dat_bit     = dat_sync_q[1];

    // Clock filter: the count only grows while the synced clock disagrees
    // with the filtered level; any agreeing sample restarts it.
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;

    // Bit timeout. An expiry coinciding with a falling edge still aborts
    // the old frame, and that edge is then treated as a fresh start bit.
    bit_expire  = (bit_cnt_q != 4'd0) && (bit_tmr_q == BIT_LAST);
    bit_cnt_eff = bit_expire ? 4'd0 : bit_cnt_q;
    bit_tmr_d   = (bit_cnt_q != 4'd0) ? bit_tmr_q + 1'b1 : '0;
    if (bit_expire) begin
      bit_cnt_d = 4'd0;
      bit_tmr_d = '0;
      err_d     = 1'b1;
    end

    if (fall_q) begin
      bit_tmr_d = '0;
      case (bit_cnt_eff)
        4'd0: begin
          // A high start bit is line noise: ignore it and stay idle.
          if (!dat_bit) begin
            bit_cnt_d = 4'd1;
            par_d     = 1'b0;
          end
        end
        4'd9: begin
          par_d     = par_q ^ dat_bit;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          if (par_q && dat_bit) byte_done = 1'b1;
          else                  frame_err = 1'b1;
        end
        default: begin
          shift_d   = {dat_bit, shift_q[7:1]};
          par_d     = par_q ^ dat_bit;
          bit_cnt_d = bit_cnt_eff + 4'd1;
        end
      endcase
    end
    if (frame_err) err_d = 1'b1;

    // Packet assembly, with the same expiry-first precedence as above.
    pkt_expire  = (pkt_idx_q != 2'd0) && (pkt_tmr_q == PKT_LAST);
    pkt_idx_eff = pkt_expire ? 2'd0 : pkt_idx_q;
    pkt_idx_d   = pkt_idx_eff;
    pkt_tmr_d   = (pkt_idx_eff != 2'd0) ? pkt_tmr_q + 1'b1 : '0;

    if (frame_err || bit_expire) begin
      pkt_idx_d = 2'd0;
      pkt_tmr_d = '0;
    end else if (byte_done && (pkt_idx_eff != 2'd0 || shift_q[3])) begin
      // Byte 0 always has bit 3 set; anything else at index 0 is a
      // misaligned byte and is dropped without an error.
      pkt_tmr_d = '0;
      if (pkt_idx_eff == IDX_LAST) begin
        pkt_idx_d = 2'd0;
`ifdef PS2_MOUSE_WHEEL_EN
        ps2_mouse_d = {~ps2_mouse_q[28], shift_q[3:0], b2_q, b1_q, b0_q};
`else
        ps2_mouse_d = {~ps2_mouse_q[28], 4'h0, shift_q, b1_q, b0_q};
`endif
      end else begin
        pkt_idx_d = pkt_idx_eff + 2'd1;
        case (pkt_idx_eff)
          2'd0:    b0_d = shift_q;
          2'd1:    b1_d = shift_q;
`ifdef PS2_MOUSE_WHEEL_EN
          default: b2_d = shift_q;
`else
          default: ;
`endif
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values computed in the previous cycle. Every register,
  // the byte staging included, is reset so partial packets never leak out.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      fall_q      <= 1'b0;
      bit_cnt_q   <= 4'd0;
      bit_tmr_q   <= '0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      pkt_idx_q   <= 2'd0;
      pkt_tmr_q   <= '0;
      b0_q        <= 8'h00;
      b1_q        <= 8'h00;
`ifdef PS2_MOUSE_WHEEL_EN
      b2_q        <= 8'h00;
`endif
      ps2_mouse_q <= 29'h0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      filt_cnt_q  <= filt_cnt_d;
      filt_q      <= filt_d;
      fall_q      <= fall_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_tmr_q   <= bit_tmr_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      pkt_idx_q   <= pkt_idx_d;
      pkt_tmr_q   <= pkt_tmr_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
`ifdef PS2_MOUSE_WHEEL_EN
      b2_q        <= b2_d;
`endif
      ps2_mouse_q <= ps2_mouse_d;
      err_q       <= err_d;
    end
  end

  assign ps2_mouse = ps2_mouse_q;
  assign err       = err_q;

endmodule
